// File: rtl/axis_packet_master.sv
// Store-and-forward AXI-Stream packet source.
// Whole packets are buffered, then sent as one contiguous burst.
module axis_packet_master #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int DEPTH             = 16,
  parameter int MAX_PKT_WORDS     = 8
) (
  input  logic                           m_axis_aclk,
  input  logic                           m_axis_areset,
  input  logic                           wr_en,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   wr_data,
  input  logic                           wr_last,
  output logic                           wr_full,
  output logic                           overflow,
  output logic [$clog2(DEPTH):0]         pkt_count,
  output logic                           m_axis_tvalid,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [C_AXIS_DATA_WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]                  r_wr_ptr;
  logic [AW:0]                  r_rd_ptr;
  logic [AW:0]                  w_count;
  logic [CW-1:0]                r_wcnt;
  logic [AW:0]                  r_pkt_count;
  logic                         r_overflow;
  logic                         r_tvalid;
  logic                         r_tlast;
  logic [C_AXIS_DATA_WIDTH-1:0] r_tdata;
  logic                         w_push;
  logic                         w_last_st;
  logic                         w_inc;
  logic                         w_pop;
  logic                         w_start;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign wr_full   = (w_count == (AW+1)'(DEPTH));
  assign w_push    = wr_en && !wr_full;
  // Cap packet length so a full FIFO always holds a complete packet
  assign w_last_st = wr_last || (r_wcnt == CW'(MAX_PKT_WORDS - 1));
  assign w_inc     = w_push && w_last_st;

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_start    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pkt_count != '0) begin
          w_start    = 1'b1;
          w_pop      = 1'b1;
          w_state_nx = S_SEND;
        end
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (r_tlast) w_state_nx = S_IDLE;
          else         w_pop      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_last_st, wr_data};
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wcnt      <= '0;
      r_pkt_count <= '0;
      r_overflow  <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tdata     <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_tvalid <= (w_state_nx == S_SEND);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wcnt   <= w_last_st ? '0 : r_wcnt + 1'b1;
      end
      if (wr_en && wr_full) r_overflow <= 1'b1;
      if (w_pop) begin
        {r_tlast, r_tdata} <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr           <= r_rd_ptr + 1'b1;
      end
      if (w_inc && !w_start)      r_pkt_count <= r_pkt_count + 1'b1;
      else if (!w_inc && w_start) r_pkt_count <= r_pkt_count - 1'b1;
    end
  end

  assign overflow      = r_overflow;
  assign pkt_count     = r_pkt_count;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tstrb  = '1;

endmodule

// File: tb/tb_axis_packet_master.sv
// Bench for axis_packet_master: directed pushes feed a scoreboard,
// a negedge monitor checks every output beat against it.
module tb_axis_packet_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_full;
  logic        overflow;
  logic [4:0]  pkt_count;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;

  always #5 clk = ~clk;

  axis_packet_master #(
    .C_AXIS_DATA_WIDTH(32),
    .DEPTH(16),
    .MAX_PKT_WORDS(8)
  ) dut (
    .m_axis_aclk(clk),
    .m_axis_areset(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_full(wr_full),
    .overflow(overflow),
    .pkt_count(pkt_count),
    .m_axis_tvalid(tvalid),
    .m_axis_tdata(tdata),
    .m_axis_tstrb(tstrb),
    .m_axis_tlast(tlast),
    .m_axis_tready(tready)
  );

  int passed = 0;
  int total  = 0;
  int beats  = 0;
  logic [32:0] sb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compare each handshake beat; check hold under stall
  logic        stall_q = 1'b0;
  logic [32:0] held_q;
  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q && tvalid)
        chk("hold", {31'd0, tlast, tdata}, {31'd0, held_q});
      if (tvalid && tready) begin
        beats++;
        chk("tstrb", 64'(tstrb), 64'hF);
        if (sb.size() == 0) begin
          chk("extra_beat", {31'd0, tlast, tdata}, 64'd0);
        end else begin
          chk("beat", {31'd0, tlast, tdata}, {31'd0, sb.pop_front()});
        end
      end
      stall_q <= tvalid && !tready;
      held_q  <= {tlast, tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_last is hand-computed (includes forced last); acc=0 for a drop
  task automatic push(input logic [31:0] d, input logic l,
                      input logic exp_last, input logic acc);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = l;
    if (acc) sb.push_back({exp_last, d});
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic wait_q(input int target, input int budget);
    int n = 0;
    while (!(sb.size() == target && !tvalid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
    tready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_pkt", 64'(pkt_count), 0);
    chk("rst_full", 64'(wr_full), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_tdata", 64'(tdata), 0);
    chk("rst_tlast", 64'(tlast), 0);

    // T1 single packet
    tready = 1'b1;
    for (int i = 0; i < 4; i++)
      push(32'hA0 + 32'(i), i == 3, i == 3, 1'b1);
    chk("t1_pkt1", 64'(pkt_count), 1);
    chk("t1_tv0", 64'(tvalid), 0);
    tick();
    chk("t1_tv1", 64'(tvalid), 1);
    chk("t1_d0", 64'(tdata), 64'hA0);
    chk("t1_pkt0", 64'(pkt_count), 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_tv", 64'(tvalid), 1);
      chk("t1_d", 64'(tdata), 64'hA0 + 64'(i));
    end
    tick();
    chk("t1_end", 64'(tvalid), 0);

    // T2 backpressure 1,0,0,...
    tready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'hB0 + 32'(i), i == 3, i == 3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !tvalid) break;
      tready = (i % 3 == 0);
      tick();
    end
    chk("t2_drain", 64'(sb.size()), 0);

    // T3 forced last after 8 words
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(32'hC0 + 32'(i), 1'b0, i == 7, 1'b1);
      if (i == 7) chk("t3_pkt1", 64'(pkt_count), 1);
      if (i == 8) begin
        chk("t3_pkt0", 64'(pkt_count), 0);
        chk("t3_tv", 64'(tvalid), 1);
        chk("t3_d0", 64'(tdata), 64'hC0);
      end
    end
    tready = 1'b1;
    wait_q(2, 40);
    chk("t3_held", 64'(pkt_count), 0);
    push(32'hCA, 1'b1, 1'b1, 1'b1);
    wait_q(0, 40);

    // T4 full / overflow (one word sits in the output register)
    tready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 18; i++) begin
      push(32'hD00 + 32'(i), 1'b0, i == 7 || i == 15, i < 17);
      if (i == 16) begin
        chk("t4_full", 64'(wr_full), 1);
        chk("t4_noovf", 64'(overflow), 0);
      end
      if (i == 17) chk("t4_ovf", 64'(overflow), 1);
    end
    tick();
    tick();
    chk("t4_sticky", 64'(overflow), 1);
    tready = 1'b1;
    wait_q(1, 60);
    chk("t4_beats", 64'(beats - b0), 16);
    chk("t4_sticky2", 64'(overflow), 1);
    push(32'hDE, 1'b1, 1'b1, 1'b1);
    wait_q(0, 40);

    // T5 back-to-back packets, simultaneous +1/-1 on pkt_count
    tready = 1'b0;
    for (int i = 0; i < 8; i++)
      push(32'hE0 + 32'(i), i == 2 || i == 5, i == 2 || i == 5, 1'b1);
    chk("t5_pkt", 64'(pkt_count), 1);
    chk("t5_d0", 64'(tdata), 64'hE0);
    tready = 1'b1;
    tick();
    chk("t5_b1", 64'(tvalid), 1);
    tick();
    chk("t5_b2", 64'(tvalid), 1);
    tick();
    chk("t5_gap", 64'(tvalid), 0);
    push(32'hE8, 1'b1, 1'b1, 1'b1);
    chk("t5_same", 64'(pkt_count), 1);
    chk("t5_tv", 64'(tvalid), 1);
    chk("t5_g0", 64'(tdata), 64'hE3);
    wait_q(0, 40);

    // T6 reset mid-packet (overflow still set from T4)
    tready = 1'b1;
    for (int i = 0; i < 4; i++)
      push(32'hF0 + 32'(i), i == 3, i == 3, 1'b1);
    push(32'hF4, 1'b0, 1'b0, 1'b1);
    push(32'hF5, 1'b1, 1'b1, 1'b1);
    tick();
    chk("t6_beat2", 64'(tdata), 64'hF2);
    chk("t6_pre_pkt", 64'(pkt_count), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("t6_tv", 64'(tvalid), 0);
    chk("t6_pkt", 64'(pkt_count), 0);
    chk("t6_full", 64'(wr_full), 0);
    chk("t6_ovf", 64'(overflow), 0);
    push(32'h60, 1'b0, 1'b0, 1'b1);
    push(32'h61, 1'b1, 1'b1, 1'b1);
    wait_q(0, 40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
